// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-to-UART drain block.
package fifo_uart_pkg;

    localparam int DATA_W_DEFAULT = 8;
    localparam int FRAME_BITS     = 10;   // start + 8 data + stop

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        START,
        DATA,
        STOP
    } state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts CLKS_PER_BIT cycles and flags the last (tick) and
// second-to-last (pre_tick) cycle of each bit period.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    output logic tick,
    output logic pre_tick
);
    localparam int CW = $clog2(CLKS_PER_BIT);

    logic [CW-1:0] cnt;

    always_ff @(posedge CLK or posedge RST) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (RST) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick     = (cnt == CW'(CLKS_PER_BIT - 1));
    assign pre_tick = (cnt == CW'(CLKS_PER_BIT - 2));

endmodule

// File: rtl/fifo_uart_drain.sv
// Pops bytes from a FIFO and serializes each one as an 8N1 UART frame on TxD.
// Outputs are registered from next-state values so they align with the state.
module fifo_uart_drain
    import fifo_uart_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEFAULT,
    parameter int CLKS_PER_BIT = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Enable,
    input  logic              Empty,
    input  logic [DATA_W-1:0] ReadData,
    output logic              REN,
    output logic              TxD,
    output logic              Busy,
    output logic              ByteDone
);
    localparam int BW = $clog2(DATA_W);

    state_t            state, state_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic [BW-1:0]     bit_cnt, bit_cnt_n;
    logic [1:0]        wait_cnt;
    logic              tick, pre_tick, baud_clr, can_start, wait_last, txd_n;

    assign can_start = Enable && !Empty;
    assign wait_last = (wait_cnt == 2'(READ_LATENCY - 1));
    assign baud_clr  = !(state inside {START, DATA, STOP});

    uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .CLK      (CLK),
        .RST      (RST),
        .clr      (baud_clr),
        .tick     (tick),
        .pre_tick (pre_tick)
    );

    always_comb begin
        // NOTE: every signal gets a default first; a path that skips an assignment would infer a latch.
        state_n   = state;
        shreg_n   = shreg;
        bit_cnt_n = bit_cnt;
        case (state)
            IDLE:  if (can_start) state_n = REQ;
            REQ:   state_n = WAIT;
            WAIT:  if (wait_last) begin
                       shreg_n = ReadData;   // the only cycle ReadData is looked at
                       state_n = START;
                   end
            START: if (tick) begin
                       bit_cnt_n = '0;
                       state_n   = DATA;
                   end
            DATA:  if (tick) begin
                       shreg_n = shreg >> 1;
                       if (bit_cnt == BW'(DATA_W - 1)) state_n = STOP;
                       else bit_cnt_n = bit_cnt + 1'b1;
                   end
            STOP:  if (tick) state_n = can_start ? REQ : IDLE;
            default: state_n = IDLE;
        endcase

        txd_n = 1'b1;
        if (state_n == START)     txd_n = 1'b0;
        else if (state_n == DATA) txd_n = shreg_n[0];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            wait_cnt <= '0;
            TxD      <= 1'b1;
            REN      <= 1'b0;
            Busy     <= 1'b0;
            ByteDone <= 1'b0;
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            bit_cnt  <= bit_cnt_n;
            wait_cnt <= (state == WAIT) ? wait_cnt + 2'd1 : 2'd0;
            TxD      <= txd_n;
            REN      <= (state_n == REQ);
            Busy     <= (state_n != IDLE);
            // Set one cycle early so the registered pulse lands on the last stop-bit cycle.
            ByteDone <= (state == STOP) && pre_tick;
        end
    end

endmodule
